// File: rtl/multimode_time_core_if.sv
// multimode_time_core_if: control, load and display signals of the time core
interface multimode_time_core_if;
    logic [1:0] mode;
    logic       load;
    logic       run_toggle;
    logic       h12;
    logic [4:0] hours_i;
    logic [5:0] mins_i;
    logic [5:0] secs_i;
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic       pm;
    logic       tick_1s;
    logic       timer_done;
    logic       expired;
    logic       load_err;
    modport master (
        output mode, load, run_toggle, h12, hours_i, mins_i, secs_i,
        input  hours, mins, secs, pm, tick_1s, timer_done, expired, load_err
    );
    modport slave (
        input  mode, load, run_toggle, h12, hours_i, mins_i, secs_i,
        output hours, mins, secs, pm, tick_1s, timer_done, expired, load_err
    );
endinterface

// File: rtl/multimode_time_core.sv
// multimode_time_core: clock, stopwatch and countdown timer sharing one 1 s tick
module multimode_time_core #(
    parameter int DIV   = 100_000_000,
    parameter int H_MAX = 24
) (
    input logic clk,
    input logic reset,
    multimode_time_core_if.slave bus
);
    localparam int DW = $clog2(DIV);

    logic [DW-1:0] div;
    logic          tick, valid, tm_load, expire, sw_run, tm_run, tm_run_nx;
    logic [16:0]   clk_t, sw_t, tm_t, clk_nx, sw_nx, tm_nx, load_t, disp_t;
    logic [4:0]    disp_h;

    // times are packed {hours[4:0], mins[5:0], secs[5:0]}
    function automatic logic [16:0] inc(input logic [16:0] t);
        logic [4:0] h;
        logic [5:0] m, s;
        {h, m, s} = t;
        if (s != 6'd59) s = s + 6'd1;
        else begin
            s = '0;
            if (m != 6'd59) m = m + 6'd1;
            else begin
                m = '0;
                h = (h == 5'(H_MAX - 1)) ? 5'd0 : h + 5'd1;
            end
        end
        return {h, m, s};
    endfunction

    function automatic logic [16:0] dec(input logic [16:0] t);
        logic [4:0] h;
        logic [5:0] m, s;
        {h, m, s} = t;
        if (s != '0) s = s - 6'd1;
        else begin
            s = 6'd59;
            if (m != '0) m = m - 6'd1;
            else begin
                m = 6'd59;
                h = h - 5'd1;
            end
        end
        return {h, m, s};
    endfunction

    assign tick        = div == DW'(DIV - 1);
    assign bus.tick_1s = tick;
    assign load_t      = {bus.hours_i, bus.mins_i, bus.secs_i};
    assign valid       = {1'b0, bus.hours_i} < 6'(H_MAX) && bus.mins_i < 6'd60 && bus.secs_i < 6'd60;
    assign tm_load     = bus.load && bus.mode == 2'b11 && valid;
    assign expire      = tick && tm_run && !tm_load && tm_t == 17'd1;

    always_comb begin
        clk_nx    = (bus.load && bus.mode == 2'b00 && valid) ? load_t : tick ? inc(clk_t) : clk_t;
        sw_nx     = (bus.load && bus.mode == 2'b10) ? '0 : (tick && sw_run) ? inc(sw_t) : sw_t;
        tm_nx     = tm_load ? load_t : (tick && tm_run && tm_t != '0) ? dec(tm_t) : tm_t;
        // a timer that would sit at zero is never allowed to start
        tm_run_nx = expire ? 1'b0 :
                    (bus.run_toggle && bus.mode == 2'b11) ? (!tm_run && tm_nx != '0) : tm_run;
        disp_t    = !bus.mode[1] ? clk_t : bus.mode[0] ? tm_t : sw_t;
        disp_h    = (bus.h12 && !bus.mode[1]) ?
                    (disp_t[16:12] == '0 ? 5'd12 : disp_t[16:12] > 5'd12 ? disp_t[16:12] - 5'd12 : disp_t[16:12]) :
                    disp_t[16:12];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div            <= '0;
            clk_t          <= '0;
            sw_t           <= '0;
            tm_t           <= '0;
            sw_run         <= 1'b0;
            tm_run         <= 1'b0;
            bus.hours      <= '0;
            bus.mins       <= '0;
            bus.secs       <= '0;
            bus.pm         <= 1'b0;
            bus.timer_done <= 1'b0;
            bus.expired    <= 1'b0;
            bus.load_err   <= 1'b0;
        end else begin
            div            <= tick ? '0 : div + 1'b1;
            clk_t          <= clk_nx;
            sw_t           <= sw_nx;
            tm_t           <= tm_nx;
            tm_run         <= tm_run_nx;
            sw_run         <= (bus.load && bus.mode == 2'b10) ? 1'b0 : sw_run ^ (bus.run_toggle && bus.mode == 2'b10);
            bus.timer_done <= expire;
            bus.expired    <= tm_load ? 1'b0 : expire ? 1'b1 : bus.expired;
            bus.load_err   <= bus.load && bus.mode[0] == bus.mode[1] && !valid;
            bus.hours      <= disp_h;
            bus.mins       <= disp_t[11:6];
            bus.secs       <= disp_t[5:0];
            bus.pm         <= bus.h12 && !bus.mode[1] && disp_t[16:12] >= 5'd12;
        end
    end
endmodule

// File: tb/tb_multimode_time_core.sv
// tb_multimode_time_core: directed plus random stimulus against a seconds-count reference model
module tb_multimode_time_core;
    localparam int DIV = 4, H_MAX = 24, MOD = H_MAX * 3600;

    logic clk = 1'b0, reset = 1'b1;
    multimode_time_core_if bus();
    multimode_time_core #(.DIV(DIV), .H_MAX(H_MAX)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int m_div, m_clk, m_sw, m_tm, m_h, m_m, m_s;
    bit m_swr, m_tmr, m_exp, m_done, m_err, m_pm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // reference: every counter is a plain number of seconds
    task automatic model();
        int v, hh, lv;
        bit tk, ok, twelve;
        if (reset) begin
            m_div = 0; m_clk = 0; m_sw = 0; m_tm = 0;
            m_swr = 0; m_tmr = 0; m_exp = 0; m_done = 0; m_err = 0; m_pm = 0;
            m_h = 0; m_m = 0; m_s = 0;
        end else begin
            tk = m_div == DIV - 1;
            m_div = (m_div + 1) % DIV;
            v = bus.mode < 2 ? m_clk : bus.mode == 2 ? m_sw : m_tm;
            hh = v / 3600;
            twelve = bus.mode < 2 && bus.h12;
            m_m = (v / 60) % 60;
            m_s = v % 60;
            m_pm = twelve && hh >= 12;
            m_h = twelve ? (hh == 0 ? 12 : hh > 12 ? hh - 12 : hh) : hh;
            ok = bus.hours_i < H_MAX && bus.mins_i < 60 && bus.secs_i < 60;
            lv = bus.hours_i * 3600 + bus.mins_i * 60 + bus.secs_i;
            m_err = bus.load && (bus.mode == 0 || bus.mode == 3) && !ok;
            if (bus.load && bus.mode == 0 && ok) m_clk = lv;
            else if (tk) m_clk = (m_clk + 1) % MOD;
            if (bus.load && bus.mode == 2) begin
                m_sw = 0;
                m_swr = 0;
            end else begin
                if (tk && m_swr) m_sw = (m_sw + 1) % MOD;
                if (bus.run_toggle && bus.mode == 2) m_swr = !m_swr;
            end
            m_done = 0;
            if (bus.load && bus.mode == 3 && ok) begin
                m_tm = lv;
                m_exp = 0;
            end else if (tk && m_tmr && m_tm > 0) begin
                m_tm--;
                if (m_tm == 0) begin
                    m_done = 1;
                    m_exp = 1;
                    m_tmr = 0;
                end
            end
            if (bus.run_toggle && bus.mode == 3 && !m_done) m_tmr = m_tmr ? 0 : m_tm != 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model();
        #1;
        check("hours", bus.hours, m_h);
        check("mins", bus.mins, m_m);
        check("secs", bus.secs, m_s);
        check("pm", bus.pm, m_pm);
        check("tick_1s", bus.tick_1s, m_div == DIV - 1);
        check("timer_done", bus.timer_done, m_done);
        check("expired", bus.expired, m_exp);
        check("load_err", bus.load_err, m_err);
        bus.load = 0;
        bus.run_toggle = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input logic [1:0] md, input int h, input int m, input int s, input bit tog);
        bus.mode = md;
        bus.hours_i = 5'(h);
        bus.mins_i = 6'(m);
        bus.secs_i = 6'(s);
        bus.load = 1;
        bus.run_toggle = tog;
        cyc();
    endtask

    task automatic toggle(input logic [1:0] md);
        bus.mode = md;
        bus.run_toggle = 1;
        cyc();
    endtask

    initial begin
        bit found;
        bus.mode = 0; bus.load = 0; bus.run_toggle = 0; bus.h12 = 0;
        bus.hours_i = 0; bus.mins_i = 0; bus.secs_i = 0;
        run(2);
        reset = 0;
        // clock rollover through midnight
        do_load(2'b00, 23, 59, 58, 0);
        run(8);
        check("t1_midnight", {bus.hours, bus.mins, bus.secs}, 0);
        // 12 h display
        do_load(2'b00, 13, 5, 0, 0);
        bus.mode = 2'b01;
        bus.h12 = 1;
        run(3);
        check("t2_h12_hours", bus.hours, 1);
        check("t2_h12_pm", bus.pm, 1);
        do_load(2'b00, 0, 0, 0, 0);
        bus.mode = 2'b01;
        run(2);
        bus.h12 = 0;
        run(3);
        // timer expiry, start at zero refused, reload clears expired
        do_load(2'b11, 0, 0, 2, 0);
        toggle(2'b11);
        run(10);
        check("t3_expired", bus.expired, 1);
        toggle(2'b11);
        run(6);
        do_load(2'b11, 0, 1, 0, 0);
        run(3);
        // stopwatch runs in the background, load+toggle clears and stops
        toggle(2'b10);
        run(13);
        bus.mode = 2'b01;
        run(8);
        bus.mode = 2'b10;
        run(3);
        do_load(2'b10, 5, 5, 5, 1);
        run(9);
        // rejected loads and load coincident with a tick
        do_load(2'b00, 24, 0, 0, 0);
        run(2);
        do_load(2'b00, 1, 60, 0, 0);
        run(2);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.tick_1s) found = 1;
            else cyc();
        end
        check("t5_tick_found", found, 1);
        do_load(2'b00, 10, 20, 30, 0);
        cyc();
        check("t5_exact_load", {bus.hours, bus.mins, bus.secs}, {5'd10, 6'd20, 6'd30});
        // reset while everything runs
        toggle(2'b10);
        do_load(2'b11, 0, 10, 0, 1);
        run(7);
        reset = 1;
        cyc();
        reset = 0;
        run(12);
        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom);
            if ($urandom_range(0, 31) == 0) bus.h12 = !bus.h12;
            bus.hours_i = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 1));
            bus.mins_i = $urandom_range(0, 3) == 0 ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 1));
            bus.secs_i = $urandom_range(0, 7) == 0 ? 6'($urandom_range(55, 63)) : 6'($urandom_range(0, 8));
            bus.load = $urandom_range(0, 11) == 0;
            bus.run_toggle = $urandom_range(0, 7) == 0;
            reset = $urandom_range(0, 499) == 0;
            cyc();
        end
        reset = 0;
        run(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
